// File: rtl/fp8_pkg.sv
// Shared FP8 definitions for the accumulator datapath.
// FP8 layout: [7] sign, [6:4] exponent (bias 3), [3:0] mantissa with hidden 1.
// An exponent field of zero flushes the value to zero. There are no inf/NaN
// encodings, so 8'h7F / 8'hFF (+/-31.0) are the largest magnitudes.
package fp8_pkg;

  localparam int unsigned SIGN_BIT  = 7;
  localparam int unsigned EXP_W     = 3;
  localparam int unsigned MAN_W     = 4;
  localparam int unsigned EXP_LSB   = MAN_W;
  localparam int unsigned EXP_BIAS  = 3;
  localparam int unsigned FRAC_BITS = 6;
  // {1,m} shifted left by at most 6 places
  localparam int unsigned TERM_W    = 11;
  localparam logic [6:0]  FP8_MAX_MAG = 7'h7F;

  typedef enum logic [1:0] {ACC, NORM, PACK, DONE} state_t;

  // Unsigned magnitude of an FP8 value in fixed point, LSB weight 2^-FRAC_BITS.
  // 1.m * 2^(e-3) == {1,m} * 2^(e-7) == {1,m} << (e-1) in 2^-6 units.
  function automatic logic [TERM_W-1:0] fp8_term_mag(input logic [7:0] f);
    logic [EXP_W-1:0]  e;
    logic [TERM_W-1:0] sig;
    e   = f[EXP_LSB +: EXP_W];
    sig = TERM_W'({1'b1, f[MAN_W-1:0]});
    if (e == '0) begin
      return '0;
    end
    return sig << (e - EXP_W'(1));
  endfunction

  function automatic logic [7:0] fp8_encode(input logic             s,
                                            input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp8_to_fixed.sv
// Combinational FP8 -> signed two's-complement fixed-point term decode.
// Ports:
//   i_fp8  [7:0]        FP8 input value
//   o_term [ACC_W-1:0]  signed term, 6 fractional bits, zero for e==0
module fp8_to_fixed
  import fp8_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic [7:0]       i_fp8,
  output logic [ACC_W-1:0] o_term
);

  logic [TERM_W-1:0] w_mag;
  logic [ACC_W-1:0]  w_ext;

  always_comb begin
    w_mag  = fp8_term_mag(i_fp8);
    w_ext  = {{(ACC_W-TERM_W){1'b0}}, w_mag};
    o_term = i_fp8[SIGN_BIT] ? (~w_ext + 1'b1) : w_ext;
  end

endmodule

// File: rtl/fp8_accumulator.sv
// Exact FP8 packet accumulator with FP8 renormalisation.
// Terms arriving over in_valid/in_ready are summed into a saturating signed
// fixed-point register. After the in_last beat the magnitude is scanned one
// bit per cycle for its leading one, packed back into FP8 (truncated) and
// presented on out_valid/out_ready.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_data/in_valid/in_last input term stream; in_ready accepts
//   out_data/out_sat         FP8 sum and saturation flag
//   out_valid/out_ready      result handshake
//   busy                     high while normalising or holding a result
module fp8_accumulator
  import fp8_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_sat,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int unsigned MAG_W = ACC_W - 1;
  localparam int unsigned PTR_W = $clog2(ACC_W);

  localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(ACC_W - 2);
  localparam logic [PTR_W-1:0] PTR_MIN  = PTR_W'(EXP_BIAS);
  // Leading-one positions below this give an exponent field of zero
  localparam logic [PTR_W-1:0] PTR_LOW  = PTR_W'(EXP_BIAS + 1);
  // Leading-one positions above this exceed the largest FP8 exponent
  localparam logic [PTR_W-1:0] PTR_EMAX = PTR_W'((2**EXP_W) - 1 + EXP_BIAS);

  localparam logic [ACC_W-1:0] ACC_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_NEG = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] SUM_POS = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_NEG = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

  state_t r_state, w_state_next;

  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic             r_sign;
  logic [MAG_W-1:0] r_mag;
  logic [PTR_W-1:0] r_ptr;
  logic             r_in_ready;
  logic [7:0]       r_out_data;
  logic             r_out_sat;

  logic [ACC_W-1:0]        w_term;
  logic signed [ACC_W:0]   w_sum;
  logic [ACC_W-1:0]        w_acc_next;
  logic                    w_clamp;
  logic [MAG_W-1:0]        w_mag_next;
  logic                    w_fire;
  logic                    w_found;
  logic [7:0]              w_pack_data;
  logic                    w_pack_sat;
  logic [EXP_W-1:0]        w_exp;
  logic [MAN_W-1:0]        w_man;

  fp8_to_fixed #(.ACC_W(ACC_W)) u_dec (
    .i_fp8  (in_data),
    .o_term (w_term)
  );

  assign w_fire = in_valid & r_in_ready;

  // Sum is formed one bit wider so overflow shows up as an out-of-range value.
  // The negative limit is symmetric, so |acc| always fits in ACC_W-1 bits.
  always_comb begin
    w_sum      = {r_acc[ACC_W-1], r_acc} + {w_term[ACC_W-1], w_term};
    w_acc_next = w_sum[ACC_W-1:0];
    w_clamp    = 1'b0;
    if (w_sum > SUM_POS) begin
      w_acc_next = ACC_POS;
      w_clamp    = 1'b1;
    end else if (w_sum < SUM_NEG) begin
      w_acc_next = ACC_NEG;
      w_clamp    = 1'b1;
    end
    w_mag_next = MAG_W'(w_acc_next[ACC_W-1] ? (~w_acc_next + 1'b1) : w_acc_next);
  end

  assign w_found = r_mag[r_ptr] | (r_ptr == PTR_MIN);

  always_comb begin
    w_pack_data = '0;
    w_pack_sat  = 1'b0;
    w_exp       = EXP_W'(r_ptr - PTR_MIN);
    w_man       = MAN_W'(r_mag >> (r_ptr - PTR_W'(MAN_W)));
    if ((r_mag == '0) || (r_ptr < PTR_LOW)) begin
      w_pack_data = '0;
    end else if ((r_ptr > PTR_EMAX) || r_sat) begin
      w_pack_data = {r_sign, FP8_MAX_MAG};
      w_pack_sat  = 1'b1;
    end else begin
      w_pack_data = fp8_encode(r_sign, w_exp, w_man);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACC:     if (w_fire && in_last) w_state_next = NORM;
      NORM:    if (w_found)           w_state_next = PACK;
      PACK:                           w_state_next = DONE;
      DONE:    if (out_ready)         w_state_next = ACC;
      default:                        w_state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_sign     <= 1'b0;
      r_mag      <= '0;
      r_ptr      <= '0;
      r_in_ready <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      // Registered ready: low through reset, high the cycle after any return to ACC
      r_in_ready <= (w_state_next == ACC);
      case (r_state)
        ACC: begin
          if (w_fire) begin
            r_acc <= w_acc_next;
            r_sat <= r_sat | w_clamp;
            if (in_last) begin
              // Magnitude is taken from the post-add value so the last beat counts
              r_sign <= w_acc_next[ACC_W-1];
              r_mag  <= w_mag_next;
              r_ptr  <= PTR_TOP;
            end
          end
        end
        NORM: begin
          if (!w_found) begin
            r_ptr <= r_ptr - 1'b1;
          end
        end
        PACK: begin
          r_out_data <= w_pack_data;
          r_out_sat  <= w_pack_sat;
        end
        DONE: begin
          if (out_ready) begin
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_out_sat <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != ACC);

endmodule

// File: tb/tb_fp8_accumulator.sv
// Directed self-checking bench for fp8_accumulator.
module tb_fp8_accumulator;

  localparam int unsigned ACC_W = 16;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_sat;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fp8_accumulator #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic send(input string tag, input logic [7:0] d, input logic l);
    int unsigned n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL %s_accept observed in_ready=%b expected=1 within 50 cycles", tag, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last beat is accepted; counts cycles to out_valid.
  task automatic wait_valid(input string tag);
    int unsigned n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (out_valid === 1'b1 && n <= ACC_W + 1) else begin
      errors++;
      $error("FAIL %s_latency observed=%0d cycles valid=%b expected<=%0d valid=1",
             tag, n, out_valid, ACC_W + 1);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic s);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_sat"},  32'(out_sat),  32'(s));
    chk({tag, "_inrdy_low"}, 32'(in_ready), 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_inrdy_back"}, 32'(in_ready),  32'd1);
    chk({tag, "_busy_low"},   32'(busy),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1.0 + 1.0 = 2.0
    send("p1", 8'h30, 1'b0);
    send("p1", 8'h30, 1'b1);
    chk("p1_busy_norm", 32'(busy), 32'd1);
    chk("p1_inrdy_norm", 32'(in_ready), 32'd0);
    wait_valid("p1");
    check_out("p1", 8'h40, 1'b0);
    handshake("p1");

    // 1.5 - 1.5 = exact zero, positive sign
    send("p2", 8'h38, 1'b0);
    send("p2", 8'hB8, 1'b1);
    wait_valid("p2");
    check_out("p2", 8'h00, 1'b0);
    handshake("p2");

    // 16.0 + 0.25 = 16.25 truncates to 16.0
    send("p3", 8'h70, 1'b0);
    send("p3", 8'h10, 1'b1);
    wait_valid("p3");
    check_out("p3", 8'h70, 1'b0);
    handshake("p3");

    // 0.25 - 0.375 = -0.125 underflows to zero
    send("p4", 8'h10, 1'b0);
    send("p4", 8'h98, 1'b1);
    wait_valid("p4");
    check_out("p4", 8'h00, 1'b0);
    handshake("p4");

    // 20 x 31.0 = 620 overflows the accumulator
    for (int i = 0; i < 20; i++) begin
      send("p5", 8'h7F, (i == 19));
    end
    wait_valid("p5");
    check_out("p5", 8'h7F, 1'b1);
    handshake("p5");

    // Sticky saturation is cleared: single-term packet of 1.0
    send("p6", 8'h30, 1'b1);
    wait_valid("p6");
    check_out("p6", 8'h30, 1'b0);
    handshake("p6");

    // -1.0 + -1.0 = -2.0
    send("p7", 8'hB0, 1'b0);
    send("p7", 8'hB0, 1'b1);
    wait_valid("p7");
    check_out("p7", 8'hC0, 1'b0);
    handshake("p7");

    // 31 + 31 = 62 fits the accumulator but exceeds FP8 range
    send("p8", 8'h7F, 1'b0);
    send("p8", 8'h7F, 1'b1);
    wait_valid("p8");
    check_out("p8", 8'h7F, 1'b1);
    handshake("p8");

    // 3.25 + 0.25 = 3.5 = 1.75 * 2^1, then hold the result for 10 cycles
    send("p9", 8'h4A, 1'b0);
    send("p9", 8'h10, 1'b1);
    wait_valid("p9");
    check_out("p9", 8'h4C, 1'b0);
    in_data  = 8'h7F;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_data",  32'(out_data),  32'h4C);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_inrdy", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    handshake("p9");

    // Beats offered during backpressure must not have been absorbed
    send("p10", 8'h30, 1'b1);
    wait_valid("p10");
    check_out("p10", 8'h30, 1'b0);
    handshake("p10");

    // Reset in the middle of a packet drops the partial sum
    send("p11", 8'h7F, 1'b0);
    send("p11", 8'h7F, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready),  32'd0);
    chk("midrst_busy",     32'(busy),      32'd0);
    chk("midrst_valid",    32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rdy_back", 32'(in_ready), 32'd1);
    send("p12", 8'h30, 1'b1);
    wait_valid("p12");
    check_out("p12", 8'h30, 1'b0);
    handshake("p12");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
